ad9361_spi_rt_ctrl: RTL

//  Runtime AD9361 register access engine; sits beside the init sequencer, downstream of ad_init_finish.

---
 rtl/ad9361_spi_rt_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ad9361_spi_rt_ctrl.sv
// Runtime AD9361 register engine: FIFO-queued host reads/writes issued to spi_core after init.
// Ports: host req/rsp, init_finish gate, spi_core set_* bus, readback. Option: AD9361_SPI_RT_TIMEOUT_EN.
module ad9361_spi_rt_ctrl #(
  parameter int         FIFO_AW     = 3,
  parameter logic [7:0] SET_ADDR    = 8'd2,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic        sys_clk_40,
  input  logic        rst,
  input  logic        init_finish,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [9:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic        rsp_wr,
  output logic [9:0]  rsp_addr,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  input  logic        spi_ready,
  input  logic        readback_stb,
  input  logic [31:0] spi_readback
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;

  logic [18:0]        mem [DEPTH];
  logic [18:0]        head;
  logic [18:0]        hold;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_nx;
  logic [7:0]         rb_byte;
  logic               push;
  logic               pop;
  logic               tmo;
  logic               err;
  logic               unused_rb;

  assign unused_rb = ^spi_readback[31:8];
  assign head      = mem[rd_ptr];
  assign push      = req_valid & req_ready;
  assign pop       = (state == IDLE) & (count != '0)
                   & init_finish & spi_ready;
  assign busy      = (count != '0) | (state != IDLE);
  assign set_addr  = SET_ADDR;

  always_ff @(posedge sys_clk_40)
    if (push) mem[wr_ptr] <= {req_wr, req_addr, req_wdata};

  always_comb begin
    count_nx = count;
    if (push && !pop)      count_nx = count + 1'b1;
    else if (pop && !push) count_nx = count - 1'b1;
  end

  // req_ready is registered from the next count, so it is 0 in
  // reset and never admits a push into a full FIFO.
  always_ff @(posedge sys_clk_40 or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nx;
      req_ready <= (count_nx != FULL);
    end
  end

  always_ff @(posedge sys_clk_40 or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pop) state_nx = ISSUE;
      ISSUE:   if (tmo) state_nx = RESP;
               else if (!spi_ready) state_nx = WAIT;
      WAIT:    if (tmo || spi_ready) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_40 or posedge rst) begin
    if (rst) begin
      set_stb  <= 1'b0;
      set_data <= '0;
      hold     <= '0;
      rb_byte  <= '0;
    end else begin
      if (pop) begin
        hold     <= head;
        set_data <= {head[18], 5'b0, head[17:0], 8'h00};
        set_stb  <= 1'b1;
        rb_byte  <= '0;
      end else if (state_nx != ISSUE) begin
        set_stb  <= 1'b0;
      end
      if (state == WAIT && readback_stb)
        rb_byte <= spi_readback[7:0];
    end
  end

`ifdef AD9361_SPI_RT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd;
  logic            wd_run;

  assign wd_run = (state == ISSUE) | (state == WAIT);
  assign tmo    = wd_run & (wd == WD_LAST);

  always_ff @(posedge sys_clk_40 or posedge rst) begin
    if (rst) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      wd <= wd_run ? wd + 1'b1 : '0;
      if (pop)      err <= 1'b0;
      else if (tmo) err <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC == 0);
  assign tmo        = 1'b0;
  assign err        = 1'b0;
`endif

  assign rsp_valid = (state == RESP);
  assign rsp_wr    = rsp_valid & hold[18];
  assign rsp_addr  = rsp_valid ? hold[17:8] : '0;
  assign rsp_rdata = (rsp_valid & ~hold[18] & ~err) ? rb_byte : '0;
  assign rsp_err   = rsp_valid & err;
endmodule
